ro_puf_engine: RTL and testbench
================================

RO_PUF_ENGINE -- requirements
Module: ro_puf_engine

Parameters
REQ-001 N_RO, default 16, number of ring-oscillator channels; power of 2, range 2..16; SEL_W = log2(N_RO).
REQ-002 CNT_W, default 16, width of each edge counter.
REQ-003 WIN_W, default 12, width of the window-length input.
REQ-004 RESP_BITS, default 8, number of response bits (comparison rounds) per challenge.
REQ-005 SETTLE_CYC, default 4, clocks the selected pair runs before counting starts; minimum 1.

Interface
REQ-006 clk  in  1  single clock for all state.
REQ-007 rst_n  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-008 ro_in  in  N_RO  raw oscillator outputs, asynchronous to clk; each frequency is below clk/2.
REQ-009 ro_en  out  N_RO  oscillator enables; at most two bits high.
REQ-010 start  in  1  request; sampled only in IDLE.
REQ-011 challenge  in  8  LFSR seed; captured with start.
REQ-012 win_len  in  WIN_W  count window in clocks; captured with start; 0 is treated as 1.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at completion.
REQ-015 response  out  RESP_BITS  response word; valid from the done pulse until the next accepted start.
REQ-016 tie_cnt  out  8  number of rounds in the last run with countA == countB.
REQ-017 count_a, count_b  out  CNT_W each  counts from the most recent round.

Function
REQ-018 FSM states and transitions:
- IDLE -> SETTLE on start.
- SETTLE (SETTLE_CYC clocks) -> COUNT.
- COUNT (W clocks) -> COMPARE.
- COMPARE (1 clock) -> SETTLE if rounds remain, else DONE.
- DONE (1 clock) -> IDLE.
REQ-019 On start acceptance:
- lfsr <= challenge, or 8'hA5 if challenge == 0.
- W <= max(win_len, 1).
- response, tie_cnt, and round index are cleared.
REQ-020 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1; round 0 uses the seed; the LFSR advances once in each COMPARE.
REQ-021 Pair selection per round:
- A = lfsr[SEL_W-1:0].
- B = lfsr[4+SEL_W-1:4].
- If A == B, then B = (A+1) mod N_RO.
REQ-022 ro_en has bits A and B high throughout SETTLE and COUNT; ro_en is 0 in IDLE, COMPARE, and DONE.
REQ-023 Edge detection: each ro_in bit passes through a 2-FF synchronizer plus a rising-edge detector.
REQ-024 Counters clear on entry to SETTLE and increment only in COUNT, once per detected edge.
REQ-025 Counters saturate at 2^CNT_W-1; they never wrap.
REQ-026 COMPARE:
- bit = (countA > countB).
- response <= {response[RESP_BITS-2:0], bit}, so round 0 ends up in the MSB.
- On a tie, the bit is 0 and tie_cnt increments.
- count_a and count_b are updated.
REQ-027 Latency: with start sampled at edge t, done is high in the cycle after edge t + RESP_BITS*(SETTLE_CYC+W+1).
REQ-028 start while busy is ignored; challenge and win_len changes while busy have no effect.
REQ-029 A ro_in edge occurring within 2 clocks of the window end may be missed; this is accepted and deterministic.

Reset
REQ-030 Reset drives all of the following to 0: state=IDLE, ro_en, busy, done, response, tie_cnt, count_a, count_b, lfsr, counters, synchronizer flops.
REQ-031 Reset mid-run takes priority over everything: ro_en=0 and busy=0 on the next cycle, with no done pulse.

Verification (N_RO=4, RESP_BITS=4, SETTLE_CYC=2, CNT_W=8 unless stated)
REQ-032 Reset: rst_n=1 for 1 clk -> busy=0, done=0, ro_en=4'b0000, response=0, tie_cnt=0.
REQ-033 Selection and latency: challenge=8'h00, win_len=20.
- Round 0 uses A=1, B=2, so ro_en=4'b0110 in SETTLE.
- done is high exactly 92 clocks after the start edge.
REQ-034 Collision: challenge=8'h11 -> A=B=1 is remapped to B=2, ro_en=4'b0110.
- ro[1] period 4 clk, ro[2] period 10 clk, win_len=40 -> count_a > count_b, response[3]=1.
REQ-035 Tie: all ro_in driven by one identical clock of period 6 clk -> response=4'b0000, tie_cnt=4.
REQ-036 Saturation and robustness:
- Setup: CNT_W=4, ro period 3 clk, win_len=100.
- Required: count_a=15, no wrap.
- Zero window: win_len=0 behaves as 1.
- Start while busy: ignored.
- Reset asserted in COUNT: ro_en=0 next clk and no done.

Source files
------------

// File: rtl/ro_puf_if.sv
// Control, oscillator and result signals of the ring-oscillator PUF engine.
interface ro_puf_if #(
    parameter int N_RO      = 16,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 12,
    parameter int RESP_BITS = 8
);
    logic [N_RO-1:0]      ro_in;
    logic [N_RO-1:0]      ro_en;
    logic                 start;
    logic [7:0]           challenge;
    logic [WIN_W-1:0]     win_len;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic [7:0]           tie_cnt;
    logic [CNT_W-1:0]     count_a;
    logic [CNT_W-1:0]     count_b;

    modport master (
        output ro_in, start, challenge, win_len,
        input  ro_en, busy, done, response, tie_cnt, count_a, count_b
    );

    modport slave (
        input  ro_in, start, challenge, win_len,
        output ro_en, busy, done, response, tie_cnt, count_a, count_b
    );
endinterface

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF: each round races two LFSR-selected oscillators over a
// fixed clock window and shifts the comparison bit into the response word.
module ro_puf_engine #(
    parameter int N_RO       = 16,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 12,
    parameter int RESP_BITS  = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    ro_puf_if.slave bus
);
    localparam int SEL_W = $clog2(N_RO);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam int RND_W = $clog2(RESP_BITS) + 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [RND_W-1:0] ROUND_LAST  = RND_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [7:0]       SEED_ZERO   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_COUNT   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [7:0]           r_lfsr;
    logic [7:0]           w_lfsr_nx;
    logic [WIN_W-1:0]     r_win;
    logic [TMR_W-1:0]     r_timer;
    logic [TMR_W-1:0]     w_timer_nx;
    logic [TMR_W-1:0]     w_win_last;
    logic [RND_W-1:0]     r_round;
    logic [N_RO-1:0]      r_sync1;
    logic [N_RO-1:0]      r_sync2;
    logic [N_RO-1:0]      r_sync_d;
    logic [N_RO-1:0]      w_rise;
    logic [CNT_W-1:0]     r_cnt_a;
    logic [CNT_W-1:0]     r_cnt_b;
    logic [SEL_W-1:0]     w_sel_a;
    logic [SEL_W-1:0]     w_sel_b;
    logic                 w_start_acc;
    logic                 w_enter_settle;
    logic                 w_bit;
    logic [N_RO-1:0]      r_ro_en;
    logic                 r_busy;
    logic                 r_done;
    logic [RESP_BITS-1:0] r_response;
    logic [7:0]           r_tie_cnt;
    logic [CNT_W-1:0]     r_count_a;
    logic [CNT_W-1:0]     r_count_b;

    // Fibonacci step for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [SEL_W-1:0] pick_b(input logic [7:0] v);
        logic [SEL_W-1:0] a;
        logic [SEL_W-1:0] b;
        a = v[SEL_W-1:0];
        b = v[4+SEL_W-1:4];
        return (a == b) ? a + SEL_W'(1) : b;
    endfunction

    function automatic logic [N_RO-1:0] pair_mask(input logic [7:0] v);
        return (N_RO'(1) << v[SEL_W-1:0]) | (N_RO'(1) << pick_b(v));
    endfunction

    assign w_start_acc    = (r_state == S_IDLE) && bus.start;
    assign w_win_last     = TMR_W'(r_win) - TMR_W'(1);
    assign w_rise         = r_sync2 & ~r_sync_d;
    assign w_sel_a        = r_lfsr[SEL_W-1:0];
    assign w_sel_b        = pick_b(r_lfsr);
    assign w_bit          = (r_cnt_a > r_cnt_b);
    assign w_enter_settle = (w_state_nx == S_SETTLE) && (r_state != S_SETTLE);

    // Next-state, phase timer and LFSR update.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:    w_state_nx = bus.start ? S_SETTLE : S_IDLE;
            S_SETTLE:  w_state_nx = (r_timer == SETTLE_LAST) ? S_COUNT : S_SETTLE;
            S_COUNT:   w_state_nx = (r_timer == w_win_last) ? S_COMPARE : S_COUNT;
            S_COMPARE: w_state_nx = (r_round == ROUND_LAST) ? S_DONE : S_SETTLE;
            S_DONE:    w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase
        w_timer_nx = (w_state_nx == r_state) ? r_timer + TMR_W'(1) : {TMR_W{1'b0}};
        if (w_start_acc) begin
            w_lfsr_nx = (bus.challenge == 8'h00) ? SEED_ZERO : bus.challenge;
        end else if (r_state == S_COMPARE) begin
            w_lfsr_nx = lfsr_next(r_lfsr);
        end else begin
            w_lfsr_nx = r_lfsr;
        end
    end

    // State, phase timer and LFSR registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_timer <= {TMR_W{1'b0}};
            r_lfsr  <= 8'h00;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_lfsr  <= w_lfsr_nx;
        end
    end

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync1  <= {N_RO{1'b0}};
            r_sync2  <= {N_RO{1'b0}};
            r_sync_d <= {N_RO{1'b0}};
        end else begin
            r_sync1  <= bus.ro_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Saturating edge counters for the selected pair, live only in COUNT.
    always_ff @(posedge clk) begin
        if (rst_n || w_enter_settle) begin
            r_cnt_a <= {CNT_W{1'b0}};
            r_cnt_b <= {CNT_W{1'b0}};
        end else if (r_state == S_COUNT) begin
            if (w_rise[w_sel_a] && (r_cnt_a != CNT_MAX)) r_cnt_a <= r_cnt_a + CNT_W'(1);
            if (w_rise[w_sel_b] && (r_cnt_b != CNT_MAX)) r_cnt_b <= r_cnt_b + CNT_W'(1);
        end
    end

    // Run setup on start and per-round result accumulation.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_win      <= {WIN_W{1'b0}};
            r_round    <= {RND_W{1'b0}};
            r_response <= {RESP_BITS{1'b0}};
            r_tie_cnt  <= 8'h00;
            r_count_a  <= {CNT_W{1'b0}};
            r_count_b  <= {CNT_W{1'b0}};
        end else if (w_start_acc) begin
            r_win      <= (bus.win_len == {WIN_W{1'b0}}) ? WIN_W'(1) : bus.win_len;
            r_round    <= {RND_W{1'b0}};
            r_response <= {RESP_BITS{1'b0}};
            r_tie_cnt  <= 8'h00;
        end else if (r_state == S_COMPARE) begin
            r_response <= {r_response[RESP_BITS-2:0], w_bit};
            if (r_cnt_a == r_cnt_b) r_tie_cnt <= r_tie_cnt + 8'd1;
            r_count_a  <= r_cnt_a;
            r_count_b  <= r_cnt_b;
            r_round    <= r_round + RND_W'(1);
        end
    end

    // Outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ro_en <= {N_RO{1'b0}};
        end else begin
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= (w_state_nx == S_DONE);
            r_ro_en <= ((w_state_nx == S_SETTLE) || (w_state_nx == S_COUNT)) ?
                       pair_mask(w_lfsr_nx) : {N_RO{1'b0}};
        end
    end

    assign bus.ro_en    = r_ro_en;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.response = r_response;
    assign bus.tie_cnt  = r_tie_cnt;
    assign bus.count_a  = r_count_a;
    assign bus.count_b  = r_count_b;
endmodule

// File: tb/tb_ro_puf_engine.sv
// Directed bench for ro_puf_engine: expected results are queued at launch and
// compared when done fires.
`timescale 1ns/1ps
module tb_ro_puf_engine;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ro_puf_if #(.N_RO(4), .CNT_W(8), .WIN_W(12), .RESP_BITS(4)) bus ();
    ro_puf_if #(.N_RO(4), .CNT_W(4), .WIN_W(12), .RESP_BITS(4)) bus4 ();

    ro_puf_engine #(.N_RO(4), .CNT_W(8), .WIN_W(12), .RESP_BITS(4), .SETTLE_CYC(2))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    ro_puf_engine #(.N_RO(4), .CNT_W(4), .WIN_W(12), .RESP_BITS(4), .SETTLE_CYC(2))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int   ch_per [4];
    int   shared_per;
    bit   shared_on;
    logic shared_r;
    logic [3:0] ro_vec;

    assign bus.ro_in  = ro_vec;
    assign bus4.ro_in = ro_vec;

    // Oscillator edges land 2 ns off any clock edge (times are 2 or 7 mod 10).
    initial begin
        shared_r = 1'b0;
        #2;
        forever begin
            if (shared_per == 0) begin shared_r = 1'b0; #10; end
            else begin #(shared_per * 5); shared_r = ~shared_r; end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_osc
        logic r;
        initial begin
            r = 1'b0;
            #2;
            forever begin
                if (ch_per[g] == 0) begin r = 1'b0; #10; end
                else begin #(ch_per[g] * 5); r = ~r; end
            end
        end
        assign ro_vec[g] = shared_on ? shared_r : r;
    end

    typedef struct {
        string      tag;
        logic [3:0] en0;
        logic [3:0] resp;
        int         ties;
        int         ca;
        int         cb;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_model(input int ch, input int w, input int cmax);
        int c;
        c = (ch_per[ch] == 0) ? 0 : w / ch_per[ch];
        return (c > cmax) ? cmax : c;
    endfunction

    task automatic push_expect(input string tag, input logic [7:0] chal, input int win, input int cmax);
        exp_t e;
        logic [7:0] s;
        logic [1:0] a;
        logic [1:0] b;
        int w;
        s = (chal == 8'h00) ? 8'hA5 : chal;
        w = (win == 0) ? 1 : win;
        e.tag = tag; e.resp = 4'b0000; e.ties = 0; e.ca = 0; e.cb = 0; e.en0 = 4'b0000;
        e.lat = 4 * (2 + w + 1);
        for (int r = 0; r < 4; r++) begin
            a = s[1:0];
            b = s[5:4];
            if (a == b) b = a + 2'd1;
            if (r == 0) e.en0 = (4'b0001 << a) | (4'b0001 << b);
            e.ca = cnt_model(int'(a), w, cmax);
            e.cb = cnt_model(int'(b), w, cmax);
            e.resp = {e.resp[2:0], (e.ca > e.cb)};
            if (e.ca == e.cb) e.ties++;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic launch(input bit sat, input logic [7:0] chal, input logic [11:0] win);
        if (sat) begin bus4.challenge = chal; bus4.win_len = win; bus4.start = 1'b1; end
        else begin bus.challenge = chal; bus.win_len = win; bus.start = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus4.start = 1'b0;
        bus.challenge = ~chal; bus4.challenge = ~chal;
        bus.win_len = 12'd7; bus4.win_len = 12'd7;
    endtask

    task automatic collect(input bit sat, input int poke_k);
        exp_t e;
        int   k;
        logic d;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_busy"}, 32'(sat ? bus4.busy : bus.busy), 32'd1);
        chk({e.tag, "_en0"}, 32'(sat ? bus4.ro_en : bus.ro_en), 32'(e.en0));
        k = 0;
        d = 1'b0;
        while (!d && k < e.lat + 50) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            d = sat ? bus4.done : bus.done;
            if (k == poke_k) begin
                bus.challenge = 8'h00; bus.win_len = 12'd5; bus.start = 1'b1;
            end else if (k == poke_k + 1) begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk({e.tag, "_latency"}, 32'(k), 32'(e.lat));
        chk({e.tag, "_resp"}, 32'(sat ? bus4.response : bus.response), 32'(e.resp));
        chk({e.tag, "_ties"}, 32'(sat ? bus4.tie_cnt : bus.tie_cnt), 32'(e.ties));
        chk({e.tag, "_cnt_a"}, sat ? 32'(bus4.count_a) : 32'(bus.count_a), 32'(e.ca));
        chk({e.tag, "_cnt_b"}, sat ? 32'(bus4.count_b) : 32'(bus.count_b), 32'(e.cb));
        @(negedge clk);
        chk({e.tag, "_done_pulse"}, 32'(sat ? bus4.done : bus.done), 32'd0);
        chk({e.tag, "_idle"}, 32'(sat ? bus4.busy : bus.busy), 32'd0);
    endtask

    task automatic set_osc(input int p0, input int p1, input int p2, input int p3, input int sh);
        ch_per[0] = p0; ch_per[1] = p1; ch_per[2] = p2; ch_per[3] = p3;
        shared_per = sh;
        shared_on  = (sh != 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        ch_per[0] = 0; ch_per[1] = 0; ch_per[2] = 0; ch_per[3] = 0;
        shared_per = 0; shared_on = 1'b0;
        bus.start = 1'b0;  bus.challenge = 8'h00;  bus.win_len = 12'd0;
        bus4.start = 1'b0; bus4.challenge = 8'h00; bus4.win_len = 12'd0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ro_en", 32'(bus.ro_en), 32'd0);
        chk("rst_resp", 32'(bus.response), 32'd0);
        chk("rst_ties", 32'(bus.tie_cnt), 32'd0);
        chk("rst_cnt_a", 32'(bus.count_a), 32'd0);
        chk("rst_sat_busy", 32'(bus4.busy), 32'd0);

        // Zero challenge falls back to A5, all oscillators quiet.
        set_osc(0, 0, 0, 0, 0);
        push_expect("sel", 8'h00, 20, 255);
        launch(1'b0, 8'h00, 12'd20);
        collect(1'b0, -10);

        // Collision remap with distinct frequencies; a start mid-run must be ignored.
        set_osc(0, 4, 10, 0, 0);
        push_expect("coll", 8'h11, 40, 255);
        launch(1'b0, 8'h11, 12'd40);
        collect(1'b0, 30);

        // Identical waveform on every channel: all rounds tie.
        set_osc(6, 6, 6, 6, 6);
        push_expect("tie", 8'h3C, 30, 255);
        launch(1'b0, 8'h3C, 12'd30);
        collect(1'b0, -10);

        // Zero window runs as a one-clock window.
        set_osc(0, 0, 0, 0, 0);
        push_expect("zwin", 8'h5A, 0, 255);
        launch(1'b0, 8'h5A, 12'd0);
        collect(1'b0, -10);

        // 4-bit counters against ~33 edges per window must stick at 15.
        set_osc(3, 3, 3, 3, 3);
        push_expect("sat", 8'h96, 100, 15);
        launch(1'b1, 8'h96, 12'd100);
        collect(1'b1, -10);

        // Reset during COUNT aborts the run without a done pulse.
        set_osc(0, 0, 0, 0, 0);
        launch(1'b0, 8'h00, 12'd50);
        repeat (5) @(negedge clk);
        chk("midrst_pre_en", 32'(bus.ro_en), 32'(4'b0110));
        chk("midrst_pre_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("midrst_ro_en", 32'(bus.ro_en), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        chk("midrst_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
